// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RV32I inter-stage pipeline registers: buffer
// state encoding and the EX/MEM payload layout.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } pipe_state_e;

    // EX/MEM bundle field widths.
    localparam int EXM_REGWRITE_W  = 1;
    localparam int EXM_MEMWRITE_W  = 1;
    localparam int EXM_RESULTSRC_W = 2;
    localparam int EXM_RD_W        = 5;
    localparam int EXM_PCPLUS4_W   = 32;
    localparam int EXM_WDATA_W     = 32;
    localparam int EXM_ALU_W       = 32;

    // Control bits with side effects live in the lowest payload bits so a
    // single CTRL_W-wide mask can scrub them on bubbles.
    localparam int EXM_REGWRITE_OFF  = 0;
    localparam int EXM_MEMWRITE_OFF  = EXM_REGWRITE_OFF + EXM_REGWRITE_W;
    localparam int EXM_RESULTSRC_OFF = EXM_MEMWRITE_OFF + EXM_MEMWRITE_W;
    localparam int EXM_RD_OFF        = EXM_RESULTSRC_OFF + EXM_RESULTSRC_W;
    localparam int EXM_PCPLUS4_OFF   = EXM_RD_OFF + EXM_RD_W;
    localparam int EXM_WDATA_OFF     = EXM_PCPLUS4_OFF + EXM_PCPLUS4_W;
    localparam int EXM_ALU_OFF       = EXM_WDATA_OFF + EXM_WDATA_W;

    localparam int EXM_W      = EXM_ALU_OFF + EXM_ALU_W;
    localparam int EXM_CTRL_W = EXM_MEMWRITE_OFF + EXM_MEMWRITE_W;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline stall/bubble statistics; holds at
// all-ones and is cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (inc && !(&r_count)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with optional two-entry skid buffer,
// flush with control-bit scrubbing, and saturating stall/bubble counters.
module pipe_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_W = EXM_W,
    parameter int CTRL_W = EXM_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a beat moves on an edge where valid && ready are both high;
    // the sender holds valid and data stable until that edge, and ready never
    // depends on valid from the same side.
    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;

    assign w_out_valid = (r_state != ST_EMPTY);
    // With the skid buffer, ready comes straight from the state register.
    assign w_in_ready  = (SKID != 0) ? (r_state != ST_FULL)
                                     : (!w_out_valid || out_ready);
    assign w_push      = in_valid && w_in_ready;
    assign w_pop       = w_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_load_main_in = 1'b1;
                    end else if (w_push) begin
                        if (SKID != 0) begin
                            w_state_nxt = ST_FULL;
                            w_load_skid = 1'b1;
                        end else begin
                            w_load_main_in = 1'b1;
                        end
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    // Side-effect controls read as zero on a bubble; payload bits above them
    // keep their last value.
    generate
        if (CTRL_W == 0) begin : g_no_scrub
            assign out_data = r_main;
        end else if (CTRL_W >= DATA_W) begin : g_full_scrub
            assign out_data = w_out_valid ? r_main : '0;
        end else begin : g_low_scrub
            assign out_data = {r_main[DATA_W-1:CTRL_W],
                               r_main[CTRL_W-1:0] & {CTRL_W{w_out_valid}}};
        end
    endgenerate

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_out_valid && !out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!w_out_valid),
        .count (bubble_cnt)
    );

    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid-mode table with scoreboard, streaming,
// async reset, counter saturation and single-register mode sequences.
module tb_pipe_stage_reg;

    localparam int TW = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_data;
    logic          flush;
    logic [15:0]   stall_cnt;
    logic [15:0]   bubble_cnt;
    logic [1:0]    dbg_state;

    logic          sat_in_ready;
    logic          sat_out_valid;
    logic [TW-1:0] sat_out_data;
    logic [3:0]    sat_stall_cnt;
    logic [3:0]    sat_bubble_cnt;
    logic [1:0]    sat_dbg_state;

    logic          s0_in_valid;
    logic          s0_in_ready;
    logic [TW-1:0] s0_in_data;
    logic          s0_out_valid;
    logic          s0_out_ready;
    logic [TW-1:0] s0_out_data;
    logic [15:0]   s0_stall_cnt;
    logic [15:0]   s0_bubble_cnt;
    logic [1:0]    s0_dbg_state;

    int checks = 0;
    int errors = 0;
    logic [TW-1:0] exp_q[$];

    typedef struct {
        logic          iv;
        logic          ordy;
        logic          fl;
        logic [TW-1:0] d;
        logic          exp_ir;
        logic          exp_ov;
        logic          chk_scrub;
    } vec_t;

    vec_t tbl[15];

    pipe_stage_reg #(.DATA_W(TW), .CTRL_W(2), .SKID(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt), .o_dbg_state(dbg_state)
    );

    pipe_stage_reg #(.DATA_W(TW), .CTRL_W(2), .SKID(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_data(in_data), .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_data(sat_out_data), .flush(flush), .stall_cnt(sat_stall_cnt),
        .bubble_cnt(sat_bubble_cnt), .o_dbg_state(sat_dbg_state)
    );

    pipe_stage_reg #(.DATA_W(TW), .CTRL_W(2), .SKID(0), .CNT_W(16)) u_s0 (
        .clk(clk), .rst(rst), .in_valid(s0_in_valid), .in_ready(s0_in_ready),
        .in_data(s0_in_data), .out_valid(s0_out_valid), .out_ready(s0_out_ready),
        .out_data(s0_out_data), .flush(1'b0), .stall_cnt(s0_stall_cnt),
        .bubble_cnt(s0_bubble_cnt), .o_dbg_state(s0_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: accepted beats queued, popped beats compared in order
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_pop", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_stall;
        int exp_bubble;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'hA0A3, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'hB0B2, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'hC0C1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'hC0C1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'hC0C1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'hC0C1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'hA0A3, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'hB0B2, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 16'hC0C1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 16'hD0D3, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 16'hE0E3, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

        rst = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        s0_in_valid = 1'b0; s0_in_data = '0; s0_out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_bubble", 32'(bubble_cnt), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_s0_in_ready", 32'(s0_in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // idle: bubble counters count, the 4-bit one saturates
        repeat (20) step();
        check("idle_bubble20", 32'(bubble_cnt), 32'd20);
        check("sat_bubble15", 32'(sat_bubble_cnt), 32'd15);
        repeat (3) step();
        check("sat_bubble_hold", 32'(sat_bubble_cnt), 32'd15);
        check("idle_bubble23", 32'(bubble_cnt), 32'd23);
        check("idle_stall", 32'(stall_cnt), 32'd0);

        // streaming 1..8 with out_ready held high
        for (int k = 0; k < 10; k++) begin
            in_valid  = (k < 8);
            in_data   = TW'(k + 1);
            out_ready = 1'b1;
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_out_valid", 32'(out_valid), 32'((k >= 1) && (k <= 8)));
            if ((k >= 1) && (k <= 8)) check("stream_latency", 32'(out_data), 32'(k));
            step();
        end
        check("stream_stall", 32'(stall_cnt), 32'd0);
        check("stream_q_empty", 32'(exp_q.size()), 32'd0);

        // fill to FULL with backpressure, then drop reset between edges
        in_valid = 1'b1; in_data = 16'h1111; out_ready = 1'b0;
        step();
        in_data = 16'h2222;
        step();
        check("pre_rst_stall", 32'(stall_cnt), 32'd1);
        check("pre_rst_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_stall", 32'(stall_cnt), 32'd0);
        check("arst_bubble", 32'(bubble_cnt), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b1;
        step();

        // backpressure and flush table
        exp_stall  = 0;
        exp_bubble = 1;
        for (int i = 0; i < 15; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
            in_data   = tbl[i].d;
            @(negedge clk);
            check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ir));
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            check($sformatf("tbl%0d_stall", i), 32'(stall_cnt), 32'(exp_stall));
            check($sformatf("tbl%0d_bubble", i), 32'(bubble_cnt), 32'(exp_bubble));
            if (tbl[i].chk_scrub) check($sformatf("tbl%0d_scrub", i), 32'(out_data[1:0]), 32'd0);
            if (tbl[i].exp_ov && !tbl[i].ordy) exp_stall++;
            if (!tbl[i].exp_ov) exp_bubble++;
            step();
        end
        flush = 1'b0; in_valid = 1'b0;
        check("tbl_final_stall", 32'(stall_cnt), 32'(exp_stall));
        check("tbl_final_bubble", 32'(bubble_cnt), 32'(exp_bubble));
        check("tbl_q_empty", 32'(exp_q.size()), 32'd0);

        // single-register mode: combinational ready and replace-in-place
        s0_in_valid = 1'b1; s0_in_data = 16'h5A5B; s0_out_ready = 1'b0;
        #1;
        check("s0_ready_empty", 32'(s0_in_ready), 32'd1);
        step();
        s0_in_data = 16'h6C6E;
        #1;
        check("s0_ready_stalled", 32'(s0_in_ready), 32'd0);
        check("s0_valid_held", 32'(s0_out_valid), 32'd1);
        check("s0_data_held", 32'(s0_out_data), 32'h5A5B);
        s0_out_ready = 1'b1;
        #1;
        check("s0_ready_comb", 32'(s0_in_ready), 32'd1);
        step();
        check("s0_replace_valid", 32'(s0_out_valid), 32'd1);
        check("s0_replace_data", 32'(s0_out_data), 32'h6C6E);
        s0_in_valid = 1'b0;
        step();
        check("s0_drain_valid", 32'(s0_out_valid), 32'd0);
        check("s0_drain_scrub", 32'(s0_out_data), 32'h6C6C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic inter-stage pipeline register for the RV32I core, replacing the fixed per-stage registers such as the EX→MEM boundary. It carries a parametrised payload bundle under a valid/ready handshake, with an optional two-entry skid buffer so upstream `in_ready` is registered. It supports pipeline flush with control-bit scrubbing and keeps saturating stall and bubble counters for performance analysis. One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface

**Parameters**
- `DATA_W`, default 105: payload width. The default is the EX/MEM bundle: ALUResult 32, WriteData 32, PCPlus4 32, Rd 5, ResultSrc 2, MemWrite 1, RegWrite 1.
- `CTRL_W`, default 2: number of low-order payload bits treated as side-effect controls (RegWrite, MemWrite). They are forced to 0 whenever `out_valid`=0. Range 0..`DATA_W`.
- `SKID`, default 1: selects the buffering mode.
  - 1 = two-entry skid buffer, registered `in_ready`.
  - 0 = single register, combinational `in_ready`.
- `CNT_W`, default 16: performance counter width.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset. Asynchronous assert, active-low (0 = reset).
- `in_valid`, input, 1: upstream beat present.
- `in_ready`, output, 1: stage can accept a beat.
- `in_data`, input, `DATA_W`: upstream payload.
- `out_valid`, output, 1: downstream beat present.
- `out_ready`, input, 1: downstream accepts.
- `out_data`, output, `DATA_W`: payload to the downstream stage.
- `flush`, input, 1: synchronous kill of all held and incoming beats.
- `stall_cnt`, output, `CNT_W`: cycles with `out_valid`=1 and `out_ready`=0.
- `bubble_cnt`, output, `CNT_W`: cycles with `out_valid`=0.

## Operation

- Push = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- **SKID=1** uses a main register, a skid register, and a 2-bit state.
  - EMPTY: push → ONE (main←in).
  - ONE:
    - push and pop → ONE (main←in).
    - push only → FULL (skid←in).
    - pop only → EMPTY.
  - FULL: pop → ONE (main←skid). No push is possible because `in_ready`=0.
  - `in_ready` = (state≠FULL), decoded from the state register only.
  - `out_valid` = (state≠EMPTY). `out_data` = main register.
- **SKID=0** uses a single register and a valid flag.
  - `in_ready` = !valid || out_ready.
  - Push loads the register. Pop without push clears valid.
- **Flush** has the highest priority.
  - Next state is EMPTY (valid=0).
  - A push in the flush cycle is accepted by the handshake and then discarded.
  - A pop in the flush cycle completes normally; downstream samples it that cycle.
- **Control scrub:** `out_data[CTRL_W-1:0]` = 0 whenever `out_valid`=0. Upper bits hold their last value.
- **Counters:**
  - Each increments by 1 per qualifying cycle and saturates at all-ones (no wrap).
  - Each is cleared only by reset.
  - `bubble_cnt` also counts flush-recovery cycles.
- **Ordering:** beats leave in arrival order. No beat is duplicated or lost except by flush.

## Timing

- Latency: a push at edge N gives `out_valid`=1 after edge N, so the beat is visible in cycle N+1.
- Throughput: 1 beat/cycle sustained when `out_ready`=1.
- After downstream deasserts `out_ready`:
  - SKID=1: absorbs exactly one extra beat, then `in_ready` falls on the next edge.
  - SKID=0: `in_ready` falls in the same cycle.
- After `out_ready` reasserts in FULL: `in_ready`=1 on the following cycle.
- Reset values (asynchronous, applied immediately while `rst`=0):
  - state EMPTY, `out_valid`=0, `in_ready`=1 (SKID=1).
  - `out_data`=0, skid register=0, `stall_cnt`=0, `bubble_cnt`=0.
- Reset deasserted mid-operation: all held beats are lost. The first push is legal on the first edge after release.
- `flush` and reset together: reset wins.

## Structure

- Shared package `riscv_pipe_pkg` holds:
  - State constants: `ST_EMPTY`=2'b00, `ST_ONE`=2'b01, `ST_FULL`=2'b10.
  - EX/MEM bundle field widths and bit offsets.
  - The `CTRL_W` ordering rule: control bits occupy the low-order payload bits.
- Sub-module `sat_counter` (parameter `CNT_W`; ports `clk`, `rst`, `inc`, `count`) is instantiated twice.

## Test plan

- **Streaming:** reset, then push 0x1..0x8 with `out_ready`=1 held. Required: outputs 0x1..0x8 on consecutive cycles, 1-cycle latency, `stall_cnt`=0.
- **Backpressure, SKID=1:** push A, B, C while `out_ready`=0. Required: A and B accepted, `in_ready`=0 before C, `stall_cnt` increments each cycle. Release `out_ready` → A, B, C emerge in order.
- **Flush:** hold FULL (A in main, B in skid), assert `flush` with `in_valid`=1 carrying C. Required: next cycle `out_valid`=0, low 2 bits of `out_data`=0, C never appears.
- **Async reset mid-stream:** drop `rst` between clock edges. Required: `out_valid`=0 and both counters 0 immediately, without waiting for a clock edge.
- **Saturation, `CNT_W`=4:** idle 20 cycles. Required: `bubble_cnt`=15 and holds.
- **SKID=0:** `out_ready`=0 with valid held. Required: `in_ready`=0 combinationally. Then push and pop in the same cycle → replaced, no bubble.
